// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle register-file datapath.
// An accepted operation either runs the ALU path
// (IDLE -> LOADA -> LOADB -> EXEC -> WB) or writes mdata/imm/pc directly
// (IDLE -> WB). Either way it writes back into the register file.
//
// Ports
//   clk, reset_n      rising-edge clock, synchronous active-low reset
//   start             request one operation (sampled in IDLE only)
//   op                00 ADD, 01 CMP (SUB, no writeback), 10 AND, 11 MVN (~B)
//   vsel              writeback source: 00 ALU, 01 mdata, 10 imm, 11 pc
//   rn, rm, rd        A-operand, B-operand and destination register indices
//   shift             B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   bsel              1: B = imm, 0: B = shifted R[rm]
//   imm               sign-extended immediate
//   mdata, pc         memory data and program counter (sampled in WB)
//   wr_en/num/data    direct register write, honoured in IDLE without start
//   dbg_num/dbg_data  combinational register read-out
//   c, status_out     ALU result register and {Z,N,V} flags
//   busy, done        non-IDLE indicator, one-cycle completion pulse
module datapath_seq #(
  parameter  int DW   = 16,
  parameter  int NREG = 8,
  parameter  int PCW  = 9,
  localparam int RW   = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [1:0]     vsel,
  input  logic [RW-1:0]  rn,
  input  logic [RW-1:0]  rm,
  input  logic [RW-1:0]  rd,
  input  logic [1:0]     shift,
  input  logic           bsel,
  input  logic [DW-1:0]  imm,
  input  logic [DW-1:0]  mdata,
  input  logic [PCW-1:0] pc,
  input  logic           wr_en,
  input  logic [RW-1:0]  wr_num,
  input  logic [DW-1:0]  wr_data,
  input  logic [RW-1:0]  dbg_num,
  output logic [DW-1:0]  dbg_data,
  output logic [DW-1:0]  c,
  output logic [2:0]     status_out,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {S_IDLE, S_LOADA, S_LOADB, S_EXEC, S_WB} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] VS_ALU = 2'b00;
  localparam logic [1:0] VS_MEM = 2'b01;
  localparam logic [1:0] VS_IMM = 2'b10;
  localparam logic [1:0] VS_PC  = 2'b11;

  state_e         state_q, state_d;
  logic [1:0]     op_q, vsel_q, shift_q;
  logic [RW-1:0]  rn_q, rm_q, rd_q;
  logic           bsel_q;
  logic [DW-1:0]  imm_q, a_q, b_q, c_q;
  logic [2:0]     status_q;
  logic           done_q;
  logic [DW-1:0]  regs_q [NREG];

  logic           accept;
  logic           wb_en;
  logic           dir_wr;
  logic [DW-1:0]  b_sh, b_op, sum, diff, res, wb_data;
  logic           ovf;
  logic [2:0]     flags;

  assign accept = (state_q == S_IDLE) && start;
  // CMP through the ALU path only sets flags; other sources still write rd.
  assign wb_en  = (state_q == S_WB) && !(vsel_q == VS_ALU && op_q == OP_CMP);
  assign dir_wr = (state_q == S_IDLE) && !start && wr_en;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (vsel == VS_ALU) ? S_LOADA : S_WB;
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift and operand selection sit in front of the ALU so B holds raw R[rm].
  always_comb begin
    b_sh = b_q;
    unique case (shift_q)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[DW-2:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[DW-1:1]};
      2'b11: b_sh = {b_q[DW-1], b_q[DW-1:1]};
    endcase
  end

  assign b_op = bsel_q ? imm_q : b_sh;
  assign sum  = a_q + b_op;
  assign diff = a_q - b_op;

  always_comb begin
    res = sum;
    ovf = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res = sum;
        ovf = (a_q[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_q[DW-1]);
      end
      OP_CMP: begin
        res = diff;
        ovf = (a_q[DW-1] != b_op[DW-1]) && (diff[DW-1] != a_q[DW-1]);
      end
      OP_AND: res = a_q & b_op;
      OP_MVN: res = ~b_op;
    endcase
  end

  assign flags = {(res == '0), res[DW-1], ovf};

  always_comb begin
    wb_data = c_q;
    unique case (vsel_q)
      VS_ALU: wb_data = c_q;
      VS_MEM: wb_data = mdata;
      VS_IMM: wb_data = imm_q;
      VS_PC:  wb_data = {{(DW-PCW){1'b0}}, pc};
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      op_q     <= '0;
      vsel_q   <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      bsel_q   <= 1'b0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      // NOTE: the register file is small and architecturally cleared by
      // reset, so it is built from flops rather than an inferred RAM.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WB);
      if (accept) begin
        op_q    <= op;
        vsel_q  <= vsel;
        shift_q <= shift;
        rn_q    <= rn;
        rm_q    <= rm;
        rd_q    <= rd;
        bsel_q  <= bsel;
        imm_q   <= imm;
      end
      if (state_q == S_LOADA) a_q <= regs_q[rn_q];
      if (state_q == S_LOADB) b_q <= regs_q[rm_q];
      if (state_q == S_EXEC) begin
        c_q      <= res;
        status_q <= flags;
      end
      // The two write ports live in different states, never both active.
      if (wb_en)       regs_q[rd_q]   <= wb_data;
      else if (dir_wr) regs_q[wr_num] <= wr_data;
    end
  end

  assign dbg_data   = regs_q[dbg_num];
  assign c          = c_q;
  assign status_out = status_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter DW, default 16, SHALL set datapath, register and immediate width (legal 8..32).
REQ-002 Parameter NREG, default 8, SHALL set register-file depth (power of 2, 2..16); RW = log2(NREG).
REQ-003 Parameter PCW, default 9, SHALL set PC width (PCW < DW).
REQ-004 Ports SHALL be:
 clk  in  1  rising-edge clock
 reset_n  in  1  synchronous reset, active low
 start  in  1  request one operation; sampled in IDLE only
 op  in  2  00 ADD, 01 CMP (SUB, no writeback), 10 AND, 11 MVN (~B)
 vsel  in  2  writeback source: 00 ALU, 01 mdata, 10 imm, 11 PC
 rn  in  RW  A-operand register
 rm  in  RW  B-operand register
 rd  in  RW  destination register
 shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
 bsel  in  1  1: B = imm, 0: B = shifted Rm
 imm  in  DW  sign-extended immediate
 mdata  in  DW  memory data
 pc  in  PCW  program counter
 wr_en  in  1  direct register write (load port)
 wr_num  in  RW  direct write index
 wr_data  in  DW  direct write data
 dbg_num  in  RW  debug read index
 dbg_data  out  DW  combinational contents of register dbg_num
 c  out  DW  ALU result register
 status_out  out  3  {Z,N,V} flags register
 busy  out  1  high in every non-IDLE state
 done  out  1  one-cycle completion pulse

Function
REQ-005 FSM states SHALL be IDLE, LOADA, LOADB, EXEC, WB.
REQ-006 In IDLE with start=1, block SHALL latch op, vsel, rn, rm, rd, shift, bsel, imm; go to LOADA if vsel=00, else to WB.
REQ-007 LOADA SHALL load A <= R[rn]; LOADB SHALL load B <= R[rm]; EXEC SHALL load c and status_out; each state lasts exactly one cycle.
REQ-008 WB SHALL write R[rd] with the vsel-selected source (C, mdata, imm, zero-extended pc), except op=CMP with vsel=00, which SHALL write nothing; WB SHALL then return to IDLE.
REQ-009 ALU latency: start at edge E0 -> result written at edge E4; done SHALL be high from E4 to E5. Non-ALU writeback: written at E1, done high E1 to E2.
REQ-010 mdata and pc SHALL be sampled in WB, not at start.
REQ-011 start while busy=1 SHALL be ignored; start in the cycle done=1 SHALL be accepted.
REQ-012 Shifter: LSL1 zero-fills bit 0; LSR1 zero-fills MSB; ASR1 replicates MSB.
REQ-013 Arithmetic SHALL be DW-bit modulo 2^DW; V = signed overflow for ADD/CMP, 0 for AND/MVN; Z = (result==0); N = result MSB.
REQ-014 status_out SHALL update in EXEC for every op; c SHALL update in EXEC for every op, including CMP.
REQ-015 wr_en SHALL write R[wr_num] <= wr_data only in IDLE with start=0; otherwise it SHALL be ignored.
REQ-016 Register reads in LOADA/LOADB SHALL see values written at prior edges (no same-edge bypass needed; no overlap occurs).
REQ-017 dbg_data SHALL reflect register contents with no added latency.

Reset
REQ-018 reset_n=0 at a rising edge SHALL clear all NREG registers, A, B, c, status_out to 0; state to IDLE; busy=0; done=0.
REQ-019 Reset in any state SHALL abort the operation; no register write and no done pulse SHALL follow.
REQ-020 Reset SHALL take priority over start and wr_en in the same cycle.

Verification
REQ-021 Load R0=5, R1=3; start ADD rn=0 rm=1 rd=2 shift=01 -> R2=11, status=000, done 4 edges after start.
REQ-022 DW=16: R0=0x7FFF, R1=1, ADD -> R2=0x8000, status {Z,N,V}=011; CMP R0,R0 -> status=100, rd unchanged.
REQ-023 R1=0x8000, MVN bsel=0 shift=11 -> result 0x3FFF written; vsel=11 pc=0x1A5 -> rd=0x01A5 with done after 1 edge.
REQ-024 start pulsed every cycle while busy -> exactly one operation per done, no extra writes; wr_en while busy -> no write.
REQ-025 reset_n low during EXEC -> all registers 0, busy=0, no done; next start completes normally.
REQ-026 NREG=16, DW=32 build: write/read all 16 registers via wr_en/dbg_num; ADD 0xFFFFFFFF+1 -> 0, status=100.
